servo_cmd_scheduler: RTL
========================

SERVO_CMD_SCHEDULER -- requirements
Module: servo_cmd_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000, meaning CLK cycles per slew tick (1 ms at 12 MHz).
REQ-002 SHALL have parameter STEP_US, default 20, meaning the maximum command change per tick per channel.
REQ-003 SHALL have parameters MIN_US 650, MAX_US 2600, CENTER_US 1500: the servo pulse-width range and the center value.
REQ-004 SHALL have parameters RAW_MIN 228 and RAW_MAX 830: the usable joystick raw range.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port sample_valid, input, 1 bit: 1-cycle strobe marking a new joystick sample.
REQ-008 SHALL have ports x_pos and y_pos, input, 10 bits each: raw joystick axes, sampled when sample_valid=1.
REQ-009 SHALL have port center_btn, input, 1 bit: level-type center request, already synchronous to CLK.
REQ-010 SHALL have port sw, input, 4 bits: channel enables; sw[i] enables servo channel i.
REQ-011 SHALL have ports servo_cmd0..servo_cmd3, output, 12 bits each: pulse-width commands in microseconds.
REQ-012 SHALL have port cmd_update, output, 1 bit: 1-cycle pulse on each slew tick.
REQ-013 SHALL have port sample_drop, output, 1 bit: 1-cycle pulse when a sample is discarded.

Function
REQ-014 SHALL run an FSM with states IDLE, MAP_X, MAP_Y and COMMIT; IDLE -> MAP_X when sample_valid=1; then MAP_X -> MAP_Y -> COMMIT -> IDLE, one cycle each.
REQ-015 SHALL latch x_pos and y_pos when leaving IDLE; sample_valid in any other state SHALL be dropped and SHALL pulse sample_drop in the same cycle.
REQ-016 SHALL map each axis through one shared multiplier, time-multiplexed (X in MAP_X, Y in MAP_Y), as follows:
- raw<=RAW_MIN -> MIN_US; raw>=RAW_MAX -> MAX_US.
- otherwise MIN_US + (((raw-RAW_MIN)*SCALE)>>8), where SCALE = floor((MAX_US-MIN_US)*256/(RAW_MAX-RAW_MIN)) = 829, fixed at elaboration.
- intermediate product is 20 bits unsigned.
REQ-017 In COMMIT, SHALL load target[i] for each enabled channel: channels 0 and 2 take the mapped X value; channels 1 and 3 take the mapped Y value. Disabled targets are held.
REQ-018 SHALL detect the rising edge of center_btn and set target[i]=CENTER_US for every enabled channel; if this coincides with COMMIT, center wins.
REQ-019 SHALL run a tick counter that wraps at TICK_DIV-1; at wrap it SHALL pulse cmd_update and move each servo_cmdi toward target[i] by min(STEP_US, |target-cmd|).
REQ-020 Slewing SHALL continue for disabled channels toward their held target.
REQ-021 A tick coinciding with a target load SHALL use the pre-load target for that cycle.
REQ-022 servo_cmdi SHALL never leave [MIN_US, MAX_US].

Reset
REQ-023 When RST=1 at a CLK edge, all of the following SHALL hold on the next cycle:
- FSM in IDLE, tick counter 0.
- all targets and servo_cmd0..3 = CENTER_US.
- cmd_update=0, sample_drop=0, center edge detector cleared.
REQ-024 Reset mid-mapping SHALL abandon the sample with no target change.

Structure
REQ-025 SHALL place MIN_US, MAX_US, CENTER_US, RAW_MIN, RAW_MAX and SCALE in a shared package servo_pkg.
REQ-026 SHALL implement per-channel slew logic as a single sub-module servo_slew, instantiated four times.

Verification
REQ-027 Bench SHALL cover: sw=4'b0001, sample x=529 -> target0=1624 four cycles after the strobe; servo_cmd0 reaches 1624 after 7 ticks (6x20, then 4).
REQ-028 Bench SHALL cover: sw=4'b0011, x=830, y=228 -> servo_cmd0 reaches 2600 after 55 ticks; servo_cmd1 reaches 650 after 43 ticks (last step 10).
REQ-029 Bench SHALL cover: second sample_valid 2 cycles after the first -> sample_drop pulse; only the first sample committed.
REQ-030 Bench SHALL cover: center_btn rising in the COMMIT cycle, sw=4'b1111 -> all targets 1500; held center_btn causes no further action.
REQ-031 Bench SHALL cover: sw[2]=0 during a sample -> target2 unchanged, channel 2 still slews to its prior target.
REQ-032 Bench SHALL cover: RST asserted in MAP_Y after servo_cmd0 has moved to 2000 -> next cycle all outputs 1500, FSM IDLE, no commit.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and types for the servo command scheduler.
//   Pulse-width range and center (microseconds), usable joystick raw range,
//   the fixed-point mapping scale, datapath widths, the FSM state type and
//   the latched joystick sample payload.
package servo_pkg;

  localparam int unsigned CMD_W  = 12;  // servo command width (us)
  localparam int unsigned RAW_W  = 10;  // joystick axis width
  localparam int unsigned PROD_W = 20;  // mapping product width

  localparam int unsigned MIN_US    = 650;
  localparam int unsigned MAX_US    = 2600;
  localparam int unsigned CENTER_US = 1500;
  localparam int unsigned RAW_MIN   = 228;
  localparam int unsigned RAW_MAX   = 830;

  // Q8 slope from raw counts to microseconds, truncated (829 for the defaults)
  localparam int unsigned SCALE = ((MAX_US - MIN_US) * 256) / (RAW_MAX - RAW_MIN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAP_X  = 2'd1,
    ST_MAP_Y  = 2'd2,
    ST_COMMIT = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic [RAW_W-1:0] x;
    logic [RAW_W-1:0] y;
  } joy_sample_t;

endpackage

// File: rtl/servo_slew.sv
// servo_slew: one servo channel's rate-limited command register.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (command returns to center)
//   tick_i   : slew tick; command moves toward the target by at most STEP_US
//   target_i : requested pulse width (us)
//   cmd_o    : current pulse-width command (us), always within [MIN_US, MAX_US]
module servo_slew
  import servo_pkg::*;
#(
  parameter int unsigned STEP_US   = 20,
  parameter int unsigned MIN_US    = servo_pkg::MIN_US,
  parameter int unsigned MAX_US    = servo_pkg::MAX_US,
  parameter int unsigned CENTER_US = servo_pkg::CENTER_US
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [CMD_W-1:0] target_i,
  output logic [CMD_W-1:0] cmd_o
);

  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [CMD_W-1:0] tgt;
  logic [CMD_W-1:0] diff;

  // Saturate the target so the command can never leave the legal range
  always_comb begin
    tgt   = target_i;
    if (tgt < CMD_W'(MIN_US)) tgt = CMD_W'(MIN_US);
    else if (tgt > CMD_W'(MAX_US)) tgt = CMD_W'(MAX_US);
    diff  = '0;
    cmd_d = cmd_q;
    if (tick_i) begin
      if (tgt > cmd_q) begin
        diff  = tgt - cmd_q;
        cmd_d = cmd_q + ((diff > CMD_W'(STEP_US)) ? CMD_W'(STEP_US) : diff);
      end else if (tgt < cmd_q) begin
        diff  = cmd_q - tgt;
        cmd_d = cmd_q - ((diff > CMD_W'(STEP_US)) ? CMD_W'(STEP_US) : diff);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cmd_q <= CMD_W'(CENTER_US);
    else       cmd_q <= cmd_d;
  end

  assign cmd_o = cmd_q;

endmodule

// File: rtl/servo_cmd_scheduler.sv
// servo_cmd_scheduler: maps joystick samples to four slew-limited servo commands.
//   CLK, RST        : clock, synchronous active-high reset
//   sample_valid    : 1-cycle strobe, x_pos/y_pos latched when accepted in IDLE
//   x_pos, y_pos    : raw joystick axes
//   center_btn      : level center request; its rising edge centers enabled targets
//   sw[3:0]         : channel enables (0,2 follow X; 1,3 follow Y)
//   servo_cmd0..3   : pulse-width commands (us)
//   cmd_update      : 1-cycle pulse on each slew tick
//   sample_drop     : combinational, high in the cycle a strobe arrives while busy
module servo_cmd_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 12000,
  parameter int unsigned STEP_US   = 20,
  parameter int unsigned MIN_US    = servo_pkg::MIN_US,
  parameter int unsigned MAX_US    = servo_pkg::MAX_US,
  parameter int unsigned CENTER_US = servo_pkg::CENTER_US,
  parameter int unsigned RAW_MIN   = servo_pkg::RAW_MIN,
  parameter int unsigned RAW_MAX   = servo_pkg::RAW_MAX
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sample_valid,
  input  logic [RAW_W-1:0] x_pos,
  input  logic [RAW_W-1:0] y_pos,
  input  logic             center_btn,
  input  logic [3:0]       sw,
  output logic [CMD_W-1:0] servo_cmd0,
  output logic [CMD_W-1:0] servo_cmd1,
  output logic [CMD_W-1:0] servo_cmd2,
  output logic [CMD_W-1:0] servo_cmd3,
  output logic             cmd_update,
  output logic             sample_drop
);

  localparam int unsigned N_CH      = 4;
  localparam int unsigned MAP_SCALE = ((MAX_US - MIN_US) * 256) / (RAW_MAX - RAW_MIN);
  localparam int unsigned CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  fsm_state_e        state_q, state_d;
  joy_sample_t       sample_q, sample_d;
  logic [CMD_W-1:0]  map_x_q, map_x_d, map_y_q, map_y_d;
  logic [CMD_W-1:0]  target_q [N_CH];
  logic [CMD_W-1:0]  target_d [N_CH];
  logic [CMD_W-1:0]  cmd_w    [N_CH];
  logic              center_q, center_rise;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick_wrap, cmd_update_q;

  logic [RAW_W-1:0]  map_raw;
  logic [PROD_W-1:0] map_prod;
  logic [CMD_W-1:0]  map_us;

  // Shared mapper: X is converted in MAP_X, Y in MAP_Y
  always_comb begin
    map_raw  = (state_q == ST_MAP_Y) ? sample_q.y : sample_q.x;
    map_prod = PROD_W'(map_raw - RAW_W'(RAW_MIN)) * PROD_W'(MAP_SCALE);
    if (map_raw <= RAW_W'(RAW_MIN))      map_us = CMD_W'(MIN_US);
    else if (map_raw >= RAW_W'(RAW_MAX)) map_us = CMD_W'(MAX_US);
    else                                 map_us = CMD_W'(MIN_US) + CMD_W'(map_prod >> 8);
  end

  // Sample FSM next state
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    map_x_d  = map_x_q;
    map_y_d  = map_y_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          sample_d.x = x_pos;
          sample_d.y = y_pos;
          state_d    = ST_MAP_X;
        end
      end
      ST_MAP_X: begin
        map_x_d = map_us;
        state_d = ST_MAP_Y;
      end
      ST_MAP_Y: begin
        map_y_d = map_us;
        state_d = ST_COMMIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sample_drop = sample_valid & (state_q != ST_IDLE);
  assign center_rise = center_btn & ~center_q;

  // Target load: a center edge overrides a simultaneous commit
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      target_d[i] = target_q[i];
      if (sw[i]) begin
        if (center_rise)                target_d[i] = CMD_W'(CENTER_US);
        else if (state_q == ST_COMMIT)  target_d[i] = ((i % 2) == 0) ? map_x_q : map_y_q;
      end
    end
  end

  // Slew tick divider
  always_comb begin
    tick_wrap  = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      sample_q     <= '0;
      map_x_q      <= CMD_W'(CENTER_US);
      map_y_q      <= CMD_W'(CENTER_US);
      for (int i = 0; i < N_CH; i++) target_q[i] <= CMD_W'(CENTER_US);
      center_q     <= 1'b0;
      tick_cnt_q   <= '0;
      cmd_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      map_x_q      <= map_x_d;
      map_y_q      <= map_y_d;
      for (int i = 0; i < N_CH; i++) target_q[i] <= target_d[i];
      center_q     <= center_btn;
      tick_cnt_q   <= tick_cnt_d;
      cmd_update_q <= tick_wrap;
    end
  end

  // Slew engines see the registered target, so a tick on a load edge uses the old one
  for (genvar g = 0; g < N_CH; g++) begin : g_slew
    servo_slew #(
      .STEP_US  (STEP_US),
      .MIN_US   (MIN_US),
      .MAX_US   (MAX_US),
      .CENTER_US(CENTER_US)
    ) u_slew (
      .clk_i   (CLK),
      .rst_i   (RST),
      .tick_i  (tick_wrap),
      .target_i(target_q[g]),
      .cmd_o   (cmd_w[g])
    );
  end

  assign servo_cmd0 = cmd_w[0];
  assign servo_cmd1 = cmd_w[1];
  assign servo_cmd2 = cmd_w[2];
  assign servo_cmd3 = cmd_w[3];
  assign cmd_update = cmd_update_q;

endmodule
